mem_arbiter: RTL

//   Shares the single external 16-bit SRAM between instruction fetch (IF) and data access (MEM stage, fed by ex_mem).

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: FSM state encoding, reset
// instruction word and SRAM strobe polarity.
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_D_RD  = 3'd1,
        ST_D_WR  = 3'd2,
        ST_D_REC = 3'd3,
        ST_I_RD  = 3'd4,
        ST_ADV   = 3'd5
    } arbState_t;

    localparam logic [15:0] NOP_INSTR = 16'h0800;

    // SRAM strobes are active-low
    localparam logic RAM_ON  = 1'b0;
    localparam logic RAM_OFF = 1'b1;

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single external SRAM between the MEM stage and instruction
// fetch; one pipeline step is [data access] -> fetch -> advance.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int          RD_CYC = 2,
    parameter int          WR_CYC = 2,
    parameter logic [15:0] NOP    = NOP_INSTR
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [15:0] IfAddr,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [15:0] MemAddr,
    input  logic [15:0] MemDataIn,
    output logic [15:0] IfData,
    output logic        IfValid,
    output logic [15:0] MemDataOut,
    output logic        MemDone,
    output logic        Stall,
    output logic [15:0] RamAddr,
    output logic [15:0] RamDataOut,
    output logic        RamDataDrv,
    input  logic [15:0] RamDataIn,
    output logic        RamOE_n,
    output logic        RamWE_n
);

    localparam int CNT_W = $clog2(maxOf(RD_CYC, WR_CYC) + 1);
    localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_CYC - 1);
    localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WR_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arbState_t        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             served_r;

    // Step sequencer; every SRAM strobe and pipeline handshake is a register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            served_r   <= 1'b0;
            IfData     <= NOP;
            IfValid    <= 1'b0;
            MemDataOut <= 16'h0000;
            MemDone    <= 1'b0;
            Stall      <= 1'b1;
            RamAddr    <= 16'h0000;
            RamDataOut <= 16'h0000;
            RamDataDrv <= 1'b0;
            RamOE_n    <= RAM_OFF;
            RamWE_n    <= RAM_OFF;
        end else begin
            MemDone <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // A simultaneous read and write resolves to the write
                    if ((MemWrite | MemRead) & ~served_r) begin
                        RamAddr <= MemAddr;
                        if (MemWrite) begin
                            state_r    <= ST_D_WR;
                            cnt_r      <= WR_LOAD;
                            RamDataOut <= MemDataIn;
                            RamDataDrv <= 1'b1;
                            RamWE_n    <= RAM_ON;
                        end else begin
                            state_r <= ST_D_RD;
                            cnt_r   <= RD_LOAD;
                            RamOE_n <= RAM_ON;
                        end
                    end else begin
                        state_r <= ST_I_RD;
                        cnt_r   <= RD_LOAD;
                        RamAddr <= IfAddr;
                        RamOE_n <= RAM_ON;
                    end
                end
                ST_D_RD: begin
                    if (cnt_r == CNT_ZERO) begin
                        MemDataOut <= RamDataIn;
                        MemDone    <= 1'b1;
                        served_r   <= 1'b1;
                        state_r    <= ST_I_RD;
                        cnt_r      <= RD_LOAD;
                        RamAddr    <= IfAddr;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_D_WR: begin
                    RamDataOut <= MemDataIn;
                    if (cnt_r == CNT_ZERO) begin
                        RamWE_n <= RAM_OFF;
                        MemDone <= 1'b1;
                        state_r <= ST_D_REC;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_D_REC: begin
                    // Data was held through the WE_n rising edge; release the bus now
                    served_r   <= 1'b1;
                    RamDataDrv <= 1'b0;
                    RamAddr    <= IfAddr;
                    RamOE_n    <= RAM_ON;
                    cnt_r      <= RD_LOAD;
                    state_r    <= ST_I_RD;
                end
                ST_I_RD: begin
                    if (cnt_r == CNT_ZERO) begin
                        IfData  <= RamDataIn;
                        RamOE_n <= RAM_OFF;
                        IfValid <= 1'b1;
                        Stall   <= 1'b0;
                        state_r <= ST_ADV;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_ADV: begin
                    IfValid  <= 1'b0;
                    Stall    <= 1'b1;
                    served_r <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= CNT_ZERO;
                    served_r   <= 1'b0;
                    IfValid    <= 1'b0;
                    Stall      <= 1'b1;
                    RamDataDrv <= 1'b0;
                    RamOE_n    <= RAM_OFF;
                    RamWE_n    <= RAM_OFF;
                end
            endcase
        end
    end

endmodule
